// File: rtl/fifo_wr_scheduler_if.sv
// Producer/FIFO write-side bundle shared by the scheduler and its environment.
// The master modport is the scheduler's view; slave is the producers plus FIFO.
interface fifo_wr_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_rd_fire;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;

  modport master (
    input  req, req_data, fifo_rd_fire, fifo_wr_ack, fifo_overflow,
    output grant, fifo_wr_en, fifo_data_in
  );

  modport slave (
    output req, req_data, fifo_rd_fire, fifo_wr_ack, fifo_overflow,
    input  grant, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_scheduler.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers,
// with credit-based flow control and sticky ack/overflow consistency checks.
module fifo_wr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CRD_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_wr_scheduler_if.master    bus,
  output logic [CRD_W-1:0]       credit,
  output logic                   err_ack,
  output logic                   err_ovf
);

  logic [PTR_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    grant_p0;
  logic [PTR_W-1:0]      win_p0;
  logic                  vld_p0;
  logic [FIFO_WIDTH-1:0] data_p0;
  int                    pos;
  logic [CRD_W:0]        step_p0;
  logic                  vld_p1;
  logic [FIFO_WIDTH-1:0] data_p1;
  logic                  vld_p2;

  // Returns {fault, next_credit}; credit saturates at 0 and FIFO_DEPTH and
  // flags any attempt to move past either end.
  function automatic logic [CRD_W:0] credit_step(input logic [CRD_W-1:0] cur,
                                                 input logic issue,
                                                 input logic rd);
    logic [CRD_W-1:0] nxt;
    logic             fault;
    nxt   = cur;
    fault = 1'b0;
    if (issue && !rd) begin
      if (cur == '0) fault = 1'b1;
      else           nxt   = cur - CRD_W'(1);
    end else if (rd && !issue) begin
      if (cur == CRD_W'(FIFO_DEPTH)) fault = 1'b1;
      else                           nxt   = cur + CRD_W'(1);
    end
    return {fault, nxt};
  endfunction

  // Stage p0: round-robin search starting at rr_ptr, gated by credit and reset
  always_comb begin
    grant_p0 = '0;
    win_p0   = '0;
    vld_p0   = 1'b0;
    pos      = 0;
    if (!rst && credit != '0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        pos = int'(rr_ptr) + i;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        if (!vld_p0 && bus.req[pos]) begin
          vld_p0        = 1'b1;
          grant_p0[pos] = 1'b1;
          win_p0        = PTR_W'(pos);
        end
      end
    end
  end

  assign data_p0 = bus.req_data[int'(win_p0)*FIFO_WIDTH +: FIFO_WIDTH];
  assign step_p0 = credit_step(credit, vld_p0, bus.fifo_rd_fire);

  // Stage p1: registered write to the FIFO; p2: expected ack slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      credit  <= CRD_W'(FIFO_DEPTH);
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      vld_p2  <= 1'b0;
      err_ack <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        data_p1 <= data_p0;
        rr_ptr  <= (win_p0 == PTR_W'(NUM_REQ - 1)) ? '0 : win_p0 + PTR_W'(1);
      end
      credit <= step_p0[CRD_W-1:0];
      vld_p2 <= vld_p1;
      if (bus.fifo_wr_ack != vld_p2)           err_ack <= 1'b1;
      if (bus.fifo_overflow || step_p0[CRD_W]) err_ovf <= 1'b1;
    end
  end

  assign bus.grant        = grant_p0;
  assign bus.fifo_wr_en   = vld_p1;
  assign bus.fifo_data_in = data_p1;

endmodule

// File: doc/fifo_wr_scheduler.md
# fifo_wr_scheduler

Round-robin write scheduler that shares the single write port of the team's synchronous FIFO (FIFO_WIDTH/FIFO_DEPTH from shared_pkg) between NUM_REQ producers. It tracks FIFO occupancy with its own credit counter, so a write is never issued into a full FIFO. It cross-checks the FIFO's wr_ack and overflow flags and latches a sticky error on any mismatch. It sits between the producer agents and the FIFO write interface. The FIFO read side stays untouched; the scheduler only observes it.

## Interface
- NUM_REQ, 4, number of producers (2..8)
- FIFO_WIDTH, 16, data width, matches FIFO
- FIFO_DEPTH, 8, FIFO capacity; initial credit count
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-producer write request, level, held until granted
- req_data  in  NUM_REQ*FIFO_WIDTH  producer i data in bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- grant  out  NUM_REQ  one-hot combinational accept, same cycle as req
- fifo_wr_en  out  1  registered write enable to FIFO
- fifo_data_in  out  FIFO_WIDTH  registered write data to FIFO
- fifo_rd_fire  in  1  FIFO read accepted this cycle (rd_en && !empty)
- fifo_wr_ack  in  1  FIFO write acknowledge
- fifo_overflow  in  1  FIFO overflow flag
- credit  out  $clog2(FIFO_DEPTH+1)  free FIFO entries as seen by scheduler
- err_ack  out  1  sticky: wr_ack disagreed with issued write
- err_ovf  out  1  sticky: FIFO overflow or credit over/underflow seen

## Operation
- State: rr_ptr (0..NUM_REQ-1), credit, wr_en_d (fifo_wr_en delayed 1), err_ack, err_ovf.
- Arbitration, combinational:
  - When credit != 0 and req != 0, grant the first set req bit searching from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
  - At most one grant bit is set.
  - grant = 0 when credit == 0 or rst high.
- Issue:
  - On a clock edge with any grant set, fifo_wr_en <= 1 and fifo_data_in <= winner's req_data.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Otherwise fifo_wr_en <= 0, fifo_data_in holds its value, rr_ptr holds.
- Credit:
  - credit_next = credit − issue + fifo_rd_fire.
  - Issue and fifo_rd_fire in the same cycle leave credit unchanged.
  - fifo_rd_fire while credit == FIFO_DEPTH with no issue: credit stays at FIFO_DEPTH and err_ovf <= 1.
- Ack check:
  - wr_en_d <= fifo_wr_en.
  - If fifo_wr_ack != wr_en_d in any cycle after reset, err_ack <= 1.
- Overflow check: fifo_overflow high in any cycle sets err_ovf <= 1.
- Error flags clear only on rst.
- Producer rule: a producer that sees grant[i] high must drop req[i] or present new data at the next edge. A held req is a new request.

## Timing
- Reset (async, immediate) values:
  - fifo_wr_en = 0, fifo_data_in = 0
  - credit = FIFO_DEPTH, rr_ptr = 0, wr_en_d = 0
  - err_ack = 0, err_ovf = 0
  - grant = 0
- Reset asserted mid-operation drops any write pending on fifo_wr_en in the same cycle, and credit returns to FIFO_DEPTH. The FIFO is reset on the same rst, so the two stay consistent.
- Cycle t: req/grant. Cycle t+1: fifo_wr_en = 1 with data. Cycle t+2: fifo_wr_ack expected = 1.
- Throughput is one write per cycle while credit > 0. Back-to-back grants to different producers are allowed.
- Credit decrements at the issuing edge (end of t), before the FIFO sees the write. This guarantees no write reaches a full FIFO.
- credit is 0 in the cycle after the FIFO_DEPTH-th outstanding write is issued. A fifo_rd_fire in that cycle restores credit to 1 at the next edge, and a grant is possible in the cycle after.
- Fairness: a continuously requesting producer waits at most NUM_REQ−1 grants when credit is available.

## Test plan
- Reset then single request:
  - Stimulus: req=4'b0100, data 0xA5A5.
  - Response: grant=4'b0100 the same cycle; fifo_wr_en=1, fifo_data_in=0xA5A5 next cycle; fifo_wr_ack=1 the cycle after; credit 8->7; rr_ptr=3.
- All four requesting continuously, no reads:
  - Response: grants rotate 0,1,2,3,0,1,2,3; after 8 issues credit=0 and grant=0; no fifo_overflow; err flags stay 0.
- Full FIFO with simultaneous read and write:
  - Stimulus: credit=0, then one fifo_rd_fire.
  - Response: credit=1; next cycle one grant and credit back to 0. Sustained read+write per cycle holds credit constant.
- Wrap-around fairness:
  - Stimulus: rr_ptr=3, req=4'b1001.
  - Response: grant=4'b1000, then grant=4'b0001, then grant=4'b1000.
- Error injection:
  - Force fifo_wr_ack=1 with no prior write -> err_ack=1, stays set until rst.
  - fifo_rd_fire with credit=8 -> err_ovf=1, credit stays 8.
- Reset mid-burst:
  - Stimulus: assert rst while fifo_wr_en=1 and credit=3.
  - Response: fifo_wr_en=0, credit=8, grant=0, err flags=0 immediately. After release, the first grant goes to the lowest set req bit from index 0.
